// File: rtl/sdram_sched_pkg.sv
// sdram_sched_pkg: scheduler FSM states, channel IDs and burst length clipping
package sdram_sched_pkg;
  typedef enum logic [1:0] {IDLE, ARB, ISSUE, BUSY} sched_state_t;
  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH_RD = 2'd2;
  function automatic logic [31:0] clip_len(input logic [31:0] remain, input logic [31:0] burst);
    return remain < burst ? remain : burst;
  endfunction
endpackage

// File: rtl/sched_wr_chan.sv
// sched_wr_chan: frame offset, ping-pong buffer and frame-start bookkeeping for one camera write channel
module sched_wr_chan import sdram_sched_pkg::*; #(
  parameter int ADDR_W = 24,
  parameter int LEN_W = 10,
  parameter int BURST_LEN = 128,
  parameter int FRAME_WORDS = 384000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sof,
  input  logic              busy,
  input  logic              done,
  input  logic              rd_own,
  input  logic              rd_buf,
  output logic [ADDR_W-1:0] offset,
  output logic [LEN_W:0]    len,
  output logic              wbuf,
  output logic              last_done,
  output logic              valid_done,
  output logic              frame_done
);
  logic sof_pend;
  logic eof;
  assign len = (LEN_W+1)'(clip_len(FRAME_WORDS - 32'(offset), BURST_LEN));
  assign eof = 32'(offset) + 32'(len) == FRAME_WORDS;
  // a frame start seen while this channel's burst is in flight waits for its completion
  always_ff @(posedge clk)
    if (rst) begin
      offset <= '0;
      wbuf <= 1'b0;
      last_done <= 1'b0;
      valid_done <= 1'b0;
      frame_done <= 1'b0;
      sof_pend <= 1'b0;
    end else begin
      frame_done <= done && eof;
      if (done) begin
        offset <= eof || sof || sof_pend ? '0 : offset + ADDR_W'(len);
        sof_pend <= 1'b0;
        if (eof) begin
          last_done <= wbuf;
          valid_done <= 1'b1;
          wbuf <= rd_own ? !rd_buf : !wbuf;
        end
      end else if (busy) sof_pend <= sof_pend || sof;
      else if (sof) offset <= '0;
    end
endmodule

// File: rtl/sdram_frame_sched.sv
// sdram_frame_sched: burst arbiter and address generator for two ping-pong camera writers and one LCD reader
module sdram_frame_sched import sdram_sched_pkg::*; #(
  parameter int ADDR_W = 24,
  parameter int LEN_W = 10,
  parameter int BURST_LEN = 128,
  parameter int FRAME_WORDS = 384000,
  parameter logic [ADDR_W-1:0] CH1_BASE = 24'h200000,
  parameter logic [ADDR_W-1:0] BUF_STRIDE = 24'h080000,
  parameter int RD_LOW = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [LEN_W:0]    wr0_cnt,
  input  logic [LEN_W:0]    wr1_cnt,
  input  logic              wr0_sof,
  input  logic              wr1_sof,
  input  logic [LEN_W:0]    rd_cnt,
  input  logic              rd_sof,
  input  logic              disp_sel,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_wr,
  output logic [1:0]        cmd_ch,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W:0]    cmd_len,
  input  logic              cmd_done,
  output logic [1:0]        frame_done
);
  sched_state_t state;
  logic [ADDR_W-1:0] w_off [2];
  logic [ADDR_W-1:0] w_addr [2];
  logic [LEN_W:0] w_len [2];
  logic [1:0] w_buf, last_done, valid_done, w_elig;
  logic rr, w_pick, in_flight;
  logic rd_ch, rbuf, rd_active, rd_pend, pend_sel, sel;
  logic rd_fly, rd_done, rd_apply, rd_elig, rd_eof;
  logic [ADDR_W-1:0] rd_off, rd_addr;
  logic [LEN_W:0] rd_len;
  assign in_flight = state == ISSUE || state == BUSY;
  for (genvar g = 0; g < 2; g++) begin : g_wr
    sched_wr_chan #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)
    ) u_chan (
      .clk(clk),
      .rst(rst),
      .sof(g ? wr1_sof : wr0_sof),
      .busy(in_flight && cmd_ch == 2'(g)),
      .done(state == BUSY && cmd_done && cmd_ch == 2'(g)),
      .rd_own(rd_active && rd_ch == 1'(g)),
      .rd_buf(rbuf),
      .offset(w_off[g]),
      .len(w_len[g]),
      .wbuf(w_buf[g]),
      .last_done(last_done[g]),
      .valid_done(valid_done[g]),
      .frame_done(frame_done[g])
    );
    assign w_addr[g] = (g ? CH1_BASE : '0) + (w_buf[g] ? BUF_STRIDE : '0) + w_off[g];
    assign w_elig[g] = w_len[g] != '0 && 32'(g ? wr1_cnt : wr0_cnt) >= 32'(w_len[g]);
  end
  assign rd_len = (LEN_W+1)'(clip_len(FRAME_WORDS - 32'(rd_off), BURST_LEN));
  assign rd_eof = 32'(rd_off) + 32'(rd_len) == FRAME_WORDS;
  assign rd_addr = (rd_ch ? CH1_BASE : '0) + (rbuf ? BUF_STRIDE : '0) + rd_off;
  assign rd_elig = rd_active && 32'(rd_cnt) < RD_LOW;
  assign rd_fly = in_flight && cmd_ch == CH_RD;
  assign rd_done = state == BUSY && cmd_done && cmd_ch == CH_RD;
  // a display switch waits until any read burst in flight has completed
  assign rd_apply = (rd_sof || rd_pend) && (!rd_fly || rd_done);
  assign sel = rd_sof ? disp_sel : pend_sel;
  assign w_pick = &w_elig ? rr : w_elig[1];
  always_ff @(posedge clk)
    if (rst) begin
      rd_ch <= 1'b0;
      rbuf <= 1'b0;
      rd_off <= '0;
      rd_active <= 1'b0;
      rd_pend <= 1'b0;
      pend_sel <= 1'b0;
    end else if (rd_apply) begin
      rd_ch <= sel;
      rbuf <= last_done[sel];
      rd_off <= '0;
      rd_active <= valid_done[sel];
      rd_pend <= 1'b0;
    end else begin
      if (rd_sof) begin
        rd_pend <= 1'b1;
        pend_sel <= disp_sel;
      end
      if (rd_done) rd_off <= rd_eof ? '0 : rd_off + ADDR_W'(rd_len);
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cmd_valid <= 1'b0;
      cmd_wr <= 1'b0;
      cmd_ch <= CH0;
      cmd_addr <= '0;
      cmd_len <= '0;
      rr <= 1'b0;
    end else
      case (state)
        IDLE: if (init_done) state <= ARB;
        ARB:
          if (init_done && (rd_elig || |w_elig)) begin
            state <= ISSUE;
            cmd_valid <= 1'b1;
            cmd_wr <= !rd_elig;
            cmd_ch <= rd_elig ? CH_RD : w_pick ? CH1 : CH0;
            cmd_addr <= rd_elig ? rd_addr : w_addr[w_pick];
            cmd_len <= rd_elig ? rd_len : w_len[w_pick];
            rr <= rd_elig ? rr : !w_pick;
          end
        ISSUE:
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state <= BUSY;
          end
        BUSY: if (cmd_done) state <= ARB;
      endcase
endmodule

// File: tb/tb_sdram_frame_sched.sv
// tb_sdram_frame_sched: directed checks of arbitration, addressing, frame wrap, ping-pong and stall behaviour
module tb_sdram_frame_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done = 1'b0;
  logic [10:0] wr0_cnt = '0, wr1_cnt = '0, rd_cnt = '0;
  logic wr0_sof = 1'b0, wr1_sof = 1'b0, rd_sof = 1'b0, disp_sel = 1'b0;
  logic cmd_ready = 1'b0, cmd_done = 1'b0;
  logic cmd_valid, cmd_wr;
  logic [1:0] cmd_ch, frame_done;
  logic [23:0] cmd_addr;
  logic [10:0] cmd_len;
  logic s_wr;
  logic [1:0] s_ch;
  logic [23:0] s_addr;
  logic [10:0] s_len;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  sdram_frame_sched dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr0_cnt(wr0_cnt), .wr1_cnt(wr1_cnt), .wr0_sof(wr0_sof), .wr1_sof(wr1_sof),
    .rd_cnt(rd_cnt), .rd_sof(rd_sof), .disp_sel(disp_sel),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr), .cmd_ch(cmd_ch),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done), .frame_done(frame_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    init_done = 1'b0;
    {wr0_cnt, wr1_cnt, rd_cnt} = '0;
    {wr0_sof, wr1_sof, rd_sof, disp_sel, cmd_ready, cmd_done} = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_valid;
    int n = 0;
    while (!cmd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_valid) begin
      check("cmd_valid_timeout", 32'(cmd_valid), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  endtask
  task automatic serve;
    wait_valid();
    {s_wr, s_ch, s_addr, s_len} = {cmd_wr, cmd_ch, cmd_addr, cmd_len};
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
  endtask
  task automatic run_frame(input logic [1:0] ch, input logic [23:0] base);
    int bad = 0;
    for (int k = 0; k < 3000; k++) begin
      serve();
      if (k == 0) check("frame_done_mid", 32'(frame_done), 0);
      if (!s_wr || s_ch != ch || s_addr != base + 24'(k * 128) || s_len != 11'd128) bad++;
    end
    check("frame_bursts", bad, 0);
    check("frame_done_end", 32'(frame_done), ch == 2'd0 ? 1 : 2);
  endtask
  initial begin
    int bad;
    do_reset();
    check("rst_valid", 32'(cmd_valid), 0);
    check("rst_wr", 32'(cmd_wr), 0);
    check("rst_ch", 32'(cmd_ch), 0);
    check("rst_addr", 32'(cmd_addr), 0);
    check("rst_len", 32'(cmd_len), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    wr0_cnt = 11'd200;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_valid) bad++;
    end
    check("no_cmd_before_init", bad, 0);
    init_done = 1'b1;
    serve();
    check("init_wr", 32'(s_wr), 1);
    check("init_ch", 32'(s_ch), 0);
    check("init_addr", 32'(s_addr), 0);
    check("init_len", 32'(s_len), 128);
    do_reset();
    init_done = 1'b1;
    wr0_cnt = 11'd200;
    wr1_cnt = 11'd200;
    serve();
    check("rr0_ch", 32'(s_ch), 0);
    check("rr0_addr", 32'(s_addr), 0);
    check("turn_gap", 32'(cmd_valid), 0);
    @(negedge clk);
    check("turn_valid", 32'(cmd_valid), 1);
    serve();
    check("rr1_ch", 32'(s_ch), 1);
    check("rr1_addr", 32'(s_addr), 32'h200000);
    serve();
    check("rr2_ch", 32'(s_ch), 0);
    check("rr2_addr", 32'(s_addr), 32'h80);
    serve();
    check("rr3_ch", 32'(s_ch), 1);
    check("rr3_addr", 32'(s_addr), 32'h200080);
    do_reset();
    init_done = 1'b1;
    wr0_cnt = 11'd200;
    serve();
    wait_valid();
    check("stall_addr", 32'(cmd_addr), 32'h80);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      wr0_sof = i == 4;
      if (!cmd_valid || cmd_addr != 24'h80 || cmd_len != 11'd128) bad++;
    end
    wr0_sof = 1'b0;
    check("stall_hold", bad, 0);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("valid_drop", 32'(cmd_valid), 0);
    cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
    serve();
    check("sof_deferred_addr", 32'(s_addr), 0);
    do_reset();
    init_done = 1'b1;
    wr0_cnt = 11'd200;
    rd_cnt = 11'd1000;
    run_frame(2'd0, 24'h0);
    serve();
    check("ch0_buf1_ch", 32'(s_ch), 0);
    check("ch0_buf1_addr", 32'(s_addr), 32'h080000);
    check("ch0_buf1_len", 32'(s_len), 128);
    wr0_cnt = '0;
    wr1_cnt = 11'd200;
    run_frame(2'd1, 24'h200000);
    serve();
    check("ch1_buf1_addr", 32'(s_addr), 32'h280000);
    wr1_cnt = '0;
    rd_sof = 1'b1;
    disp_sel = 1'b1;
    rd_cnt = 11'd100;
    @(negedge clk);
    rd_sof = 1'b0;
    disp_sel = 1'b0;
    wr0_cnt = 11'd200;
    wr1_cnt = 11'd200;
    serve();
    check("rd_wr", 32'(s_wr), 0);
    check("rd_ch", 32'(s_ch), 2);
    check("rd_addr", 32'(s_addr), 32'h200000);
    check("rd_len", 32'(s_len), 128);
    rd_cnt = 11'd1000;
    serve();
    check("after_rd_ch0_ch", 32'(s_ch), 0);
    check("after_rd_ch0_addr", 32'(s_addr), 32'h080080);
    serve();
    check("after_rd_ch1_ch", 32'(s_ch), 1);
    check("after_rd_ch1_addr", 32'(s_addr), 32'h280080);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
